key_scan: RTL and testbench
===========================

# key_scan

Debounced push-button front end for the board's key inputs, the input-side counterpart to the LED output drivers. Samples N active-low mechanical keys on the 1 MHz system clock, synchronises and debounces each one with a per-key state machine, and presents a clean level plus single-cycle press and release pulses to downstream control logic such as pattern select or speed change. Optional long-press detection.

## Interface
- `N_KEY`, 4: number of keys, 1..8.
- `CLK_HZ`, 1_000_000: system clock frequency in Hz; must be a multiple of 1000.
- `DEBOUNCE_MS`, 20: debounce window in ms ticks, ≥2.
- `LONG_MS`, 1000: long-press threshold in ms ticks, > `DEBOUNCE_MS`; used only with `KEY_LONGPRESS_EN`.
- `clk1MHz` input 1: system clock, all logic on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `key_n` input N_KEY: raw key pins, asynchronous; 0 = pressed.
- `key_level` output N_KEY: debounced state; 1 = pressed.
- `key_press` output N_KEY: one-cycle pulse per confirmed press.
- `key_release` output N_KEY: one-cycle pulse per confirmed release.
- `key_long` output N_KEY: one-cycle pulse at long-press threshold. Tied to 0 without `KEY_LONGPRESS_EN`.

## Operation
- Shared ms tick: counter 0..CLK_HZ/1000-1; `tick` is high for one cycle when the counter wraps. Reset clears the counter.
- Per key: two-flop synchroniser. Reset value is 1 (released). Bit `s` = synchronised `~key_n`.
- Per-key FSM; a 16-bit tick counter `cnt` is cleared on every state change.
  - IDLE: `s`=1 → PRESS_WAIT.
  - PRESS_WAIT: `s`=0 → IDLE, no pulse. On `tick`, `cnt`++. When a `tick` arrives with `cnt`==DEBOUNCE_MS-1 → PRESSED, and `key_press` pulses.
  - PRESSED: `s`=0 → RELEASE_WAIT. With `KEY_LONGPRESS_EN`, `cnt`++ on `tick` and saturates. On the tick where `cnt` reaches LONG_MS-1, `key_long` pulses once. There is no auto-repeat.
  - RELEASE_WAIT: `s`=1 → PRESSED, no pulse, and the long-press count restarts. On `tick`, `cnt`++. When a `tick` arrives with `cnt`==DEBOUNCE_MS-1 → IDLE, and `key_release` pulses.
- `key_level` = 1 in PRESSED and RELEASE_WAIT, 0 otherwise.
- Keys are fully independent. Simultaneous presses on several keys give pulses in the same cycle when their windows expire together.
- Every press pulse is followed by exactly one release pulse before the next press pulse. `key_long` only appears between the two.
- A long press still ends with `key_release`.

## Timing
- All outputs are registered. Reset values: `key_level`=0, `key_press`=0, `key_release`=0, `key_long`=0. All FSMs start in IDLE, all counters at 0.
- Input to `s` latency: 2 cycles.
- The press is confirmed DEBOUNCE_MS ticks after the first tick seen in PRESS_WAIT. Actual delay is (DEBOUNCE_MS-1) to DEBOUNCE_MS ms, plus 3 cycles.
- Pulses assert in the cycle after the confirming `tick` and last exactly one cycle.
- Any bounce shorter than the window produces no pulse and no `key_level` change.
- Asserting `rst_n` mid-debounce or mid-press clears everything immediately. Releasing it with a key held gives a fresh debounce, then a `key_press`.
- The `cnt` increment saturates at all-ones. No wrap-around can fake a threshold.

## Configuration
- `KEY_LONGPRESS_EN` defined: PRESSED-state tick counting and `key_long` generation are compiled in.
- `KEY_LONGPRESS_EN` undefined: the logic is removed, `key_long` is constant 0, and `LONG_MS` is ignored. Press and release behaviour are identical in both builds.

## Test plan
Bench parameters: CLK_HZ=10_000 (10 cycles/tick), DEBOUNCE_MS=3, LONG_MS=8, N_KEY=4.
- Reset: hold `rst_n`=0 with `key_n`=4'b0000 → all outputs 0. Release reset → `key_press`=4'b1111 once, after 3 ticks.
- Clean press on key0 held 100 cycles, then released → one `key_press[0]` pulse, then one `key_release[0]` pulse. `key_level[0]` is high only between the pulses.
- Bounce: key1 toggled every 7 cycles for 60 cycles, then held pressed → no pulse during bouncing. Exactly one `key_press[1]` follows 3 ticks after the last toggle.
- Long press on key2 held 120 cycles with `KEY_LONGPRESS_EN` → `key_press[2]`, then a single `key_long[2]` 8 ticks later, then `key_release[2]` after release. Without the macro, `key_long` stays 0.
- Release glitch: key3 pressed, then a 15-cycle release glitch → no `key_release[3]`, and `key_level[3]` stays 1.
- `rst_n` pulsed low during PRESS_WAIT of key0 → no `key_press[0]`. The FSM restarts from IDLE.

Source files
------------

// File: rtl/key_scan.sv
`default_nettype none
// ============================================================================
// Module   : key_scan
// Purpose  : Debounced front end for N active-low mechanical keys. Each key
//            is synchronised, debounced by its own four-state machine, and
//            presented as a clean level plus one-cycle press/release pulses.
// Option   : define KEY_LONGPRESS_EN to enable the one-shot long-press pulse
//            (key_long); without it key_long is constant 0.
// Revision : 1.0 - initial release
// ============================================================================
module key_scan #(
    parameter int N_KEY       = 4,
    parameter int CLK_HZ      = 1_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic             clk1MHz,
    input  logic             rst_n,
    input  logic [N_KEY-1:0] key_n,
    output logic [N_KEY-1:0] key_level,
    output logic [N_KEY-1:0] key_press,
    output logic [N_KEY-1:0] key_release,
    output logic [N_KEY-1:0] key_long
);

    // Millisecond prescaler sizing; a 1 kHz clock degenerates to a tick every cycle.
    localparam int c_DIV   = CLK_HZ / 1000;
    localparam int c_DIV_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);

    // Tick-count thresholds: a window closes when a tick arrives with cnt at LAST.
    localparam logic [15:0] c_DEB_LAST  = 16'(DEBOUNCE_MS - 1);
    localparam logic [15:0] c_LONG_LAST = 16'(LONG_MS - 1);
    localparam logic [15:0] c_CNT_MAX   = 16'hFFFF;

`ifdef KEY_LONGPRESS_EN
    localparam bit c_LONG_EN = 1'b1;
`else
    localparam bit c_LONG_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [c_DIV_W-1:0] r_div;
    logic               w_tick;
    logic [N_KEY-1:0]   r_sync0;
    logic [N_KEY-1:0]   r_sync1;
    logic [N_KEY-1:0]   w_s;

    assign w_tick = (r_div == c_DIV_LAST);
    assign w_s    = ~r_sync1;

    // Shared ms prescaler: tick is the wrap cycle of the counter.
    always_ff @(posedge clk1MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

    // Two-flop synchroniser on the raw pins; resets to "released".
    always_ff @(posedge clk1MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= '1;
            r_sync1 <= '1;
        end else begin
            r_sync0 <= key_n;
            r_sync1 <= r_sync0;
        end
    end

    for (genvar k = 0; k < N_KEY; k++) begin : g_key
        state_t      r_state;
        state_t      w_state_nx;
        logic [15:0] r_cnt;
        logic [15:0] w_cnt_nx;
        logic [15:0] w_cnt_inc;
        logic        r_level;
        logic        r_press;
        logic        r_release;
        logic        r_long;
        logic        w_level_nx;
        logic        w_press_nx;
        logic        w_release_nx;
        logic        w_long_nx;

        // Saturating increment so a long hold can never wrap onto a threshold.
        assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 16'd1;

        // Key state register plus registered outputs.
        always_ff @(posedge clk1MHz or negedge rst_n) begin
            if (!rst_n) begin
                r_state   <= IDLE;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
                r_long    <= 1'b0;
            end else begin
                r_state   <= w_state_nx;
                r_cnt     <= w_cnt_nx;
                r_level   <= w_level_nx;
                r_press   <= w_press_nx;
                r_release <= w_release_nx;
                r_long    <= w_long_nx;
            end
        end

        // Next-state, tick counting and pulse decode; cnt clears on every state change.
        always_comb begin
            w_state_nx   = r_state;
            w_cnt_nx     = r_cnt;
            w_press_nx   = 1'b0;
            w_release_nx = 1'b0;
            w_long_nx    = 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_s[k]) begin
                        w_state_nx = PRESS_WAIT;
                        w_cnt_nx   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_s[k]) begin
                        w_state_nx = IDLE;
                        w_cnt_nx   = '0;
                    end else if (w_tick) begin
                        if (r_cnt == c_DEB_LAST) begin
                            w_state_nx = PRESSED;
                            w_cnt_nx   = '0;
                            w_press_nx = 1'b1;
                        end else begin
                            w_cnt_nx = w_cnt_inc;
                        end
                    end
                end
                PRESSED: begin
                    if (!w_s[k]) begin
                        w_state_nx = RELEASE_WAIT;
                        w_cnt_nx   = '0;
                    end else if (c_LONG_EN && w_tick) begin
                        w_cnt_nx = w_cnt_inc;
                        // Fires only on the tick that moves cnt past the
                        // threshold, so a saturated count cannot repeat it.
                        if ((r_cnt == c_LONG_LAST) && (r_cnt != c_CNT_MAX)) begin
                            w_long_nx = 1'b1;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (w_s[k]) begin
                        w_state_nx = PRESSED;
                        w_cnt_nx   = '0;
                    end else if (w_tick) begin
                        if (r_cnt == c_DEB_LAST) begin
                            w_state_nx   = IDLE;
                            w_cnt_nx     = '0;
                            w_release_nx = 1'b1;
                        end else begin
                            w_cnt_nx = w_cnt_inc;
                        end
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end
            endcase
            w_level_nx = (w_state_nx == PRESSED) || (w_state_nx == RELEASE_WAIT);
        end

        assign key_level[k]   = r_level;
        assign key_press[k]   = r_press;
        assign key_release[k] = r_release;
        assign key_long[k]    = r_long;
    end

endmodule
`default_nettype wire

// File: tb/tb_key_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_scan
// Purpose  : Self-checking bench for key_scan. Directed scenarios followed by
//            random key activity, all compared cycle by cycle against a
//            toggle-based debounce model; build with KEY_LONGPRESS_EN to
//            cover the long-press pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_scan;

    localparam int N_KEY  = 4;
    localparam int CLK_HZ = 10_000;
    localparam int DEB    = 3;
    localparam int LONG   = 8;
    localparam int DIV    = CLK_HZ / 1000;
`ifdef KEY_LONGPRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic             clk1MHz = 1'b0;
    logic             rst_n   = 1'b0;
    logic [N_KEY-1:0] key_n   = '1;
    logic [N_KEY-1:0] key_level;
    logic [N_KEY-1:0] key_press;
    logic [N_KEY-1:0] key_release;
    logic [N_KEY-1:0] key_long;

    key_scan #(
        .N_KEY      (N_KEY),
        .CLK_HZ     (CLK_HZ),
        .DEBOUNCE_MS(DEB),
        .LONG_MS    (LONG)
    ) u_dut (
        .clk1MHz    (clk1MHz),
        .rst_n      (rst_n),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 clk1MHz = ~clk1MHz;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: each key is a debounced level that toggles once the
    // pin has disagreed with it for DEB consecutive ticks; pins reach the
    // decision logic after a two-sample delay line.
    int               m_phase;
    logic [N_KEY-1:0] m_dly [2];
    bit               m_lvl  [N_KEY];
    bit               m_wait [N_KEY];
    int               m_wticks [N_KEY];
    int               m_hticks [N_KEY];
    logic [N_KEY-1:0] exp_level, exp_press, exp_release, exp_long;

    // Pulse tallies of what the DUT actually produced, for window checks.
    int n_press [N_KEY];
    int n_release [N_KEY];
    int n_long [N_KEY];
    int n_all_press;

    task automatic model_edge();
        bit               tick;
        logic [N_KEY-1:0] s;
        exp_press   = '0;
        exp_release = '0;
        exp_long    = '0;
        if (!rst_n) begin
            m_phase  = 0;
            m_dly[0] = '1;
            m_dly[1] = '1;
            for (int k = 0; k < N_KEY; k++) begin
                m_lvl[k] = 0; m_wait[k] = 0; m_wticks[k] = 0; m_hticks[k] = 0;
            end
            exp_level = '0;
            return;
        end
        tick     = (m_phase == DIV - 1);
        m_phase  = (m_phase + 1) % DIV;
        s        = ~m_dly[1];
        m_dly[1] = m_dly[0];
        m_dly[0] = key_n;
        for (int k = 0; k < N_KEY; k++) begin
            if (!m_wait[k]) begin
                if (s[k] != m_lvl[k]) begin
                    m_wait[k]   = 1;
                    m_wticks[k] = 0;
                end else if (m_lvl[k] && LONG_EN && tick) begin
                    m_hticks[k]++;
                    if (m_hticks[k] == LONG) exp_long[k] = 1'b1;
                end
            end else if (s[k] == m_lvl[k]) begin
                m_wait[k]   = 0;
                m_hticks[k] = 0;
            end else if (tick) begin
                m_wticks[k]++;
                if (m_wticks[k] == DEB) begin
                    m_lvl[k]    = !m_lvl[k];
                    m_wait[k]   = 0;
                    m_hticks[k] = 0;
                    if (m_lvl[k]) exp_press[k] = 1'b1;
                    else          exp_release[k] = 1'b1;
                end
            end
            exp_level[k] = m_lvl[k];
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < N_KEY; k++) begin
            n_press[k] = 0; n_release[k] = 0; n_long[k] = 0;
        end
        n_all_press = 0;
    endtask

    // One clock: evaluate the edge just passed, compare, then drive new pins.
    task automatic step(input logic [N_KEY-1:0] kn);
        @(negedge clk1MHz);
        model_edge();
        check("level",   key_level,   exp_level);
        check("press",   key_press,   exp_press);
        check("release", key_release, exp_release);
        check("long",    key_long,    exp_long);
        for (int k = 0; k < N_KEY; k++) begin
            n_press[k]   += int'(key_press[k]);
            n_release[k] += int'(key_release[k]);
            n_long[k]    += int'(key_long[k]);
        end
        if (key_press == '1) n_all_press++;
        key_n = kn;
    endtask

    task automatic run(input int n, input logic [N_KEY-1:0] kn);
        for (int i = 0; i < n; i++) step(kn);
    endtask

    initial begin
        logic [N_KEY-1:0] rk;

        // Reset held with every key pressed: all outputs quiet.
        key_n = 4'b0000;
        clear_counts();
        run(5, 4'b0000);
        check("rst_level",   key_level,   4'h0);
        check("rst_press",   key_press,   4'h0);
        check("rst_release", key_release, 4'h0);
        check("rst_long",    key_long,    4'h0);
        rst_n = 1'b1;
        run(45, 4'b0000);
        check("rst_all_press_once", n_all_press, 1);
        run(45, 4'b1111);

        // Clean press/release on key0.
        clear_counts();
        run(100, 4'b1110);
        run(50, 4'b1111);
        check("k0_press_cnt",   n_press[0],   1);
        check("k0_release_cnt", n_release[0], 1);

        // Bounce on key1, then a solid hold.
        clear_counts();
        for (int i = 0; i < 60; i++) step(((i / 7) % 2 == 0) ? 4'b1101 : 4'b1111);
        check("k1_bounce_press", n_press[1], 0);
        run(50, 4'b1101);
        check("k1_hold_press", n_press[1], 1);
        run(50, 4'b1111);

        // Long hold on key2.
        clear_counts();
        run(120, 4'b1011);
        run(50, 4'b1111);
        check("k2_press_cnt",   n_press[2],   1);
        check("k2_long_cnt",    n_long[2],    LONG_EN ? 1 : 0);
        check("k2_release_cnt", n_release[2], 1);

        // Short release glitch on a held key3.
        run(50, 4'b0111);
        clear_counts();
        run(15, 4'b1111);
        run(50, 4'b0111);
        check("k3_glitch_release", n_release[3], 0);
        check("k3_glitch_level",   key_level[3], 1'b1);
        run(50, 4'b1111);

        // Reset pulse while key0 is still debouncing.
        clear_counts();
        run(15, 4'b1110);
        rst_n = 1'b0;
        run(5, 4'b1111);
        rst_n = 1'b1;
        run(50, 4'b1111);
        check("k0_rst_press", n_press[0], 0);
        check("k0_rst_level", key_level[0], 1'b0);

        // Random activity: a bouncy phase, then a slow phase with long holds.
        rk = '1;
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < N_KEY; k++) begin
                if ($urandom_range(0, (i < 1000) ? 30 : 150) == 0) rk[k] = ~rk[k];
            end
            step(rk);
        end
        run(60, 4'b1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
